// File: rtl/serial_pattern_tx_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_LEN_W      = 4;
  localparam int DEF_GAP_CYCLES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// Shifts a latched word out MSB-first on x_out, then drives a forced-zero gap
// so a downstream sequence detector always sees a terminating 0.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  // One down-counter serves as both the remaining-bit count and the gap count.
  localparam int MAX_CNT = max_int(WIDTH, GAP_CYCLES);
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Handshake: a word is taken on a rising edge where valid_in && ready_out;
  // ready_out is high only in IDLE and never depends on valid_in.
  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len_clamped;
  logic [WIDTH-1:0] aligned;

  assign len_clamped = (len_in > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_in;
  // Left-align the selected bits so the frame always leaves from the top bit.
  assign aligned     = data_in << (LEN_W'(WIDTH) - len_clamped);

  assign ready_out = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x_out <= 1'b0;
      done  <= 1'b0;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          x_out <= 1'b0;
          if (valid_in) begin
            if (len_clamped != '0) begin
              state <= SHIFT;
              x_out <= aligned[WIDTH-1];
              sh    <= aligned << 1;
              cnt   <= CNT_W'(len_clamped - LEN_W'(1));
            end else begin
              done <= 1'b1;
              sh   <= '0;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
                cnt   <= GAP_LOAD;
              end
            end
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            x_out <= 1'b0;
            done  <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            x_out <= sh[WIDTH-1];
            sh    <= sh << 1;
            cnt   <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          x_out <= 1'b0;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          x_out <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_serial_pattern_tx;
  import serial_pattern_tx_pkg::*;

  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int GAP_N = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [LW-1:0] len_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out, x_out, busy, done;
  state_t        state_dbg;

  int errors = 0;
  int checks = 0;

  serial_pattern_tx #(.WIDTH(W), .LEN_W(LW), .GAP_CYCLES(GAP_N)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .len_in(len_in),
    .valid_in(valid_in), .ready_out(ready_out), .x_out(x_out), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // ---------------- reference model: expected outputs per future cycle ----
  typedef struct packed {
    logic x;
    logic d;
    logic r;
    logic b;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic x, input logic d, input logic r, input logic b);
    exp_t e;
    e.x = x; e.d = d; e.r = r; e.b = b;
    return e;
  endfunction

  function automatic exp_t cur_exp();
    if (exp_q.size() != 0) return exp_q[0];
    return mk(1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  always @(posedge clock or negedge reset) begin
    exp_t c;
    int   n;
    if (!reset) begin
      exp_q.delete();
    end else begin
      c = cur_exp();
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (c.r && valid_in) begin
        n = (int'(len_in) > W) ? W : int'(len_in);
        for (int i = n - 1; i >= 0; i--)
          exp_q.push_back(mk(((data_in >> i) & 8'd1) != 8'd0, 1'b0, 1'b0, 1'b1));
        for (int g = 0; g < GAP_N; g++)
          exp_q.push_back(mk(1'b0, g == 0, 1'b0, 1'b1));
        if (GAP_N == 0) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
      end
    end
  end

  // ---------------- every-cycle compare against the model ----------------
  always @(negedge clock) begin
    exp_t e;
    e = cur_exp();
    checks++;
    if ({x_out, done, ready_out, busy} !== e || ((state_dbg == IDLE) !== e.r)) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t x/done/ready/busy got=%b%b%b%b expected=%b state=%0d",
               $time, x_out, done, ready_out, busy, e, state_dbg);
    end
  end

  // ---------------- driver and literal-check tasks ----------------
  task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l, input bit hold);
    logic r;
    @(posedge clock); #1;
    data_in = d; len_in = l; valid_in = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clock); r = ready_out;
      @(posedge clock);
      if (r) begin
        #1;
        if (!hold) valid_in = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout ready_out never high, got=%b required=1", ready_out);
    valid_in = 1'b0;
  endtask

  task automatic lit(input string nm, input logic ex, input logic ed, input logic er);
    @(negedge clock);
    checks++;
    if (x_out !== ex || done !== ed || ready_out !== er) begin
      errors++;
      $display("FAIL %s x/done/ready got=%b%b%b required=%b%b%b", nm, x_out, done, ready_out, ex, ed, er);
    end
  endtask

  task automatic lit_bits(input string nm, input logic [W-1:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) lit(nm, ((pat >> i) & 8'd1) != 8'd0, 1'b0, 1'b0);
    lit({nm, "_gap0"}, 1'b0, 1'b1, 1'b0);
    lit({nm, "_gap1"}, 1'b0, 1'b0, 1'b0);
    lit({nm, "_idle"}, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, got=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    #1;
    checks++;
    if (x_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state x/ready/busy/done got=%b%b%b%b required=0100", x_out, ready_out, busy, done);
    end
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);

    // 0x07 / len 3: three ones, two gap zeros, done on the first gap cycle
    send(8'h07, 4'd3, 1'b0);
    lit_bits("t2_07", 8'h07, 3);

    send(8'hA5, 4'd8, 1'b0);
    lit_bits("t3_a5", 8'hA5, 8);
    send(8'hFF, 4'd12, 1'b0);
    lit_bits("t3_clamp", 8'hFF, 8);

    // len 0: no data bits, done in k+1, gap still runs
    send(8'hFF, 4'd0, 1'b0);
    lit("t4_len0_a", 1'b0, 1'b1, 1'b0);
    lit("t4_len0_b", 1'b0, 1'b0, 1'b0);
    lit("t4_len0_idle", 1'b0, 1'b0, 1'b1);

    // valid_in toggled while busy must not disturb the frame
    send(8'h05, 4'd3, 1'b0);
    lit("t4_busy_b2", 1'b1, 1'b0, 1'b0);
    data_in = 8'hFF; len_in = 4'd8; valid_in = 1'b1;
    lit("t4_busy_b1", 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;
    lit("t4_busy_b0", 1'b1, 1'b0, 1'b0);
    valid_in = 1'b1;
    lit("t4_busy_g0", 1'b0, 1'b1, 1'b0);
    valid_in = 1'b0;
    lit("t4_busy_g1", 1'b0, 1'b0, 1'b0);
    lit("t4_busy_idle", 1'b0, 1'b0, 1'b1);

    // valid held high: 1,1,0,0,0,1,1,0,0,0
    send(8'h03, 4'd2, 1'b1);
    lit("t5_a1", 1'b1, 1'b0, 1'b0);
    lit("t5_a0", 1'b1, 1'b0, 1'b0);
    lit("t5_ag0", 1'b0, 1'b1, 1'b0);
    lit("t5_ag1", 1'b0, 1'b0, 1'b0);
    lit("t5_idle", 1'b0, 1'b0, 1'b1);
    lit("t5_b1", 1'b1, 1'b0, 1'b0);
    valid_in = 1'b0;
    lit("t5_b0", 1'b1, 1'b0, 1'b0);
    lit("t5_bg0", 1'b0, 1'b1, 1'b0);
    lit("t5_bg1", 1'b0, 1'b0, 1'b0);
    lit("t5_idle2", 1'b0, 1'b0, 1'b1);

    // reset during the third bit of 0xFF / len 8
    send(8'hFF, 4'd8, 1'b0);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (x_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t6_abort x/ready/busy/done got=%b%b%b%b required=0100", x_out, ready_out, busy, done);
    end
    @(negedge clock); #1 reset = 1'b1;
    repeat (3) lit("t6_no_done", 1'b0, 1'b0, 1'b1);
    send(8'h01, 4'd1, 1'b0);
    lit_bits("t6_after", 8'h01, 1);

    // randomized traffic, occasional asynchronous reset pulse
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      valid_in = ($urandom_range(0, 2) != 0);
      data_in  = W'($urandom_range(0, 255));
      len_in   = LW'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock); #1 reset = 1'b1;
      end
    end
    valid_in = 1'b0;
    repeat (20) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
